// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the datapath.
// State codes live here so that EXEC (4'd1) is defined in exactly one place.
package instr_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_EXEC  = 4'd1,
    ST_FETCH = 4'd2,
    ST_LATCH = 4'd3,
    ST_HALT  = 4'd4,
    ST_PAUSE = 4'd5
  } seq_state_e;

  localparam logic [7:0] HALT_OP_DEFAULT = 8'hFF;
  localparam logic [7:0] NOP_OP_DEFAULT  = 8'h00;

  // Instruction word field positions
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 24;
  localparam int unsigned OPND0_MSB = 23;
  localparam int unsigned OPND0_LSB = 18;

  function automatic logic [7:0] instr_op(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: walks the instruction ROM, latches each word onto
// instr0, presents EXEC to the datapath, handles NOP/HALT and counts retired
// instructions.
// Optional feature macro: SEQ_SINGLE_STEP_EN (EXEC -> PAUSE, advance on step).
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [7:0]  HALT_OP = HALT_OP_DEFAULT,
  parameter logic [7:0]  NOP_OP  = NOP_OP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr0,
  output logic [3:0]        current_state,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       retired
);

  seq_state_e        state_q, state_n;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic [31:0]       retired_q;
  logic              pc_clr;
  logic              pc_inc;
  logic              ld_instr;
  logic              ret_inc;
  logic [7:0]        fetched_op;

`ifndef SEQ_SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  assign fetched_op = instr_op(imem_data);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state decode and datapath update strobes
  always_comb begin
    state_n  = state_q;
    pc_clr   = 1'b0;
    pc_inc   = 1'b0;
    ld_instr = 1'b0;
    ret_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_clr  = 1'b1;
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_n = ST_LATCH;
      end
      ST_LATCH: begin
        // ROM data is valid here; decode it directly rather than from instr0
        ld_instr = 1'b1;
        if (fetched_op == HALT_OP) begin
          state_n = ST_HALT;
        end else if (fetched_op == NOP_OP) begin
          pc_inc  = 1'b1;
          ret_inc = 1'b1;
          state_n = ST_FETCH;
        end else begin
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_inc  = 1'b1;
        ret_inc = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        state_n = ST_PAUSE;
`else
        state_n = ST_FETCH;
`endif
      end
      ST_HALT: begin
        if (start) begin
          pc_clr  = 1'b1;
          state_n = ST_FETCH;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (step) begin
          state_n = ST_FETCH;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // PC, latched instruction word and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      if (pc_clr) begin
        pc_q <= '0;
      end else if (pc_inc) begin
        pc_q <= pc_q + ADDR_W'(1);
      end
      if (ld_instr) begin
        instr_q <= imem_data;
      end
      if (ret_inc) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr0        = instr_q;
  assign retired       = retired_q;
  assign current_state = state_q;
  assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected EXEC/HALT
// records, monitors pop and compare whenever the DUT presents them.
module tb_instr_sequencer;

  localparam logic [31:0] LIMM = 32'h0204_0005;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFF00_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] ret;
  } rec_t;

  logic        clk;
  logic        rst_n, rst_b;
  logic        start_a, start_b, step;
  logic [9:0]  imem_addr_a;
  logic [31:0] imem_data_a, instr0_a, retired_a;
  logic [3:0]  state_a;
  logic [9:0]  pc_a;
  logic        halted_a;
  logic [1:0]  imem_addr_b, pc_b;
  logic [31:0] imem_data_b, instr0_b, retired_b;
  logic [3:0]  state_b;
  logic        halted_b;

  logic [31:0] rom_a [0:1023];
  logic [31:0] rom_b [0:3];

  rec_t exec_q_a[$], halt_q_a[$], exec_q_b[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic prev_halted_a = 1'b0;

  instr_sequencer #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .step(step),
    .imem_addr(imem_addr_a), .imem_data(imem_data_a), .instr0(instr0_a),
    .current_state(state_a), .pc(pc_a), .halted(halted_a), .retired(retired_a)
  );

  instr_sequencer #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .step(step),
    .imem_addr(imem_addr_b), .imem_data(imem_data_b), .instr0(instr0_b),
    .current_state(state_b), .pc(pc_b), .halted(halted_b), .retired(retired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs: data valid one cycle after address
  always @(posedge clk) begin
    imem_data_a <= rom_a[imem_addr_a];
    imem_data_b <= rom_b[imem_addr_b];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", nm);
  endtask

  // Monitor A: EXEC records and HALT entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (state_a == 4'd1) begin
        if (exec_q_a.size() == 0) pop_fail("exec_a_unexpected");
        else begin
          rec_t r;
          r = exec_q_a.pop_front();
          chk("exec_a_instr0", instr0_a, r.instr);
          chk("exec_a_pc", {22'd0, pc_a}, r.pc);
          chk("exec_a_retired", retired_a, r.ret);
        end
      end
      if (halted_a && !prev_halted_a) begin
        if (halt_q_a.size() == 0) pop_fail("halt_a_unexpected");
        else begin
          rec_t r;
          r = halt_q_a.pop_front();
          chk("halt_a_state", {28'd0, state_a}, 32'd4);
          chk("halt_a_instr0", instr0_a, r.instr);
          chk("halt_a_pc", {22'd0, pc_a}, r.pc);
          chk("halt_a_retired", retired_a, r.ret);
        end
      end
    end
    prev_halted_a <= halted_a;
  end

  // Monitor B: EXEC records of the narrow-PC instance
  always @(negedge clk) begin
    if (rst_b && state_b == 4'd1) begin
      if (exec_q_b.size() == 0) pop_fail("exec_b_unexpected");
      else begin
        rec_t r;
        r = exec_q_b.pop_front();
        chk("exec_b_instr0", instr0_b, r.instr);
        chk("exec_b_pc", {30'd0, pc_b}, r.pc);
        chk("exec_b_retired", retired_b, r.ret);
      end
    end
  end

  task automatic reset_a();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_halt_a(input string nm);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (halted_a) break;
    end
    chk(nm, {31'd0, halted_a}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_state"}, {28'd0, state_a}, 32'd0);
    chk({nm, "_instr0"}, instr0_a, 32'd0);
    chk({nm, "_pc"}, {22'd0, pc_a}, 32'd0);
    chk({nm, "_imem_addr"}, {22'd0, imem_addr_a}, 32'd0);
    chk({nm, "_halted"}, {31'd0, halted_a}, 32'd0);
    chk({nm, "_retired"}, retired_a, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rst_b = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
`else
    step = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) rom_a[i] = HALT;
    for (int i = 0; i < 4; i++) rom_b[i] = LIMM;

    // Reset values
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    rst_b = 1'b1;

    // Single LIMM16 then HALT, with start-to-EXEC latency
    rom_a[0] = LIMM;
    rom_a[1] = HALT;
    exec_q_a.push_back('{LIMM, 32'd0, 32'd0});
    halt_q_a.push_back('{HALT, 32'd1, 32'd1});
    pulse_start_a();
    chk("lat_fetch", {28'd0, state_a}, 32'd2);
    chk("lat_fetch_addr", {22'd0, imem_addr_a}, 32'd0);
    @(negedge clk);
    chk("lat_latch", {28'd0, state_a}, 32'd3);
    @(negedge clk);
    chk("lat_exec", {28'd0, state_a}, 32'd1);
    wait_halt_a("halt1_reached");

    // NOP, LIMM16, HALT from fresh reset
    reset_a();
    rom_a[0] = NOP;
    rom_a[1] = LIMM;
    rom_a[2] = HALT;
    exec_q_a.push_back('{LIMM, 32'd1, 32'd1});
    halt_q_a.push_back('{HALT, 32'd2, 32'd2});
    pulse_start_a();
    wait_halt_a("halt2_reached");
    @(negedge clk);
    chk("halt2_hold_pc", {22'd0, pc_a}, 32'd2);

    // Restart from HALT; retired keeps counting
    exec_q_a.push_back('{LIMM, 32'd1, 32'd3});
    halt_q_a.push_back('{HALT, 32'd2, 32'd4});
    pulse_start_a();
    chk("restart_fetch", {28'd0, state_a}, 32'd2);
    chk("restart_pc", {22'd0, pc_a}, 32'd0);
    chk("restart_halted", {31'd0, halted_a}, 32'd0);
    wait_halt_a("halt3_reached");

    // Reset in LATCH aborts the instruction
    pulse_start_a();
    @(negedge clk);
    chk("abort_in_latch", {28'd0, state_a}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int unsigned non_idle;
      non_idle = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (state_a != 4'd0) non_idle++;
      end
      chk("abort_stays_idle", non_idle, 32'd0);
    end

    // Narrow PC wraps 0,1,2,3,0
    for (int i = 0; i < 5; i++) exec_q_b.push_back('{LIMM, 32'(i % 4), 32'(i)});
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (exec_q_b.size() == 0) break;
    end
    chk("wrap_all_exec", 32'(exec_q_b.size()), 32'd0);
    chk("wrap_retired", retired_b, 32'd5);
    rst_b = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: PAUSE holds until step
    step = 1'b0;
    exec_q_a.push_back('{LIMM, 32'd1, 32'd1});
    pulse_start_a();
    for (int i = 0; i < 30; i++) begin
      if (state_a == 4'd5) break;
      @(negedge clk);
    end
    chk("pause_reached", {28'd0, state_a}, 32'd5);
    begin
      int unsigned not_paused;
      not_paused = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (state_a != 4'd5) not_paused++;
      end
      chk("pause_hold", not_paused, 32'd0);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_fetch", {28'd0, state_a}, 32'd2);
    chk("step_pc", {22'd0, pc_a}, 32'd2);
    rst_n = 1'b0;
    step = 1'b1;
    @(negedge clk);
`endif

    @(negedge clk);
    chk("exec_a_drained", 32'(exec_q_a.size()), 32'd0);
    chk("halt_a_drained", 32'(halt_q_a.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
